// File: rtl/match_extractor.sv
// rtl/match_extractor.sv - shift-or filter vector to per-packet candidate record stream
// Turns each 0 bit of a 256-bit filter beat into an {offset, filter} record; ends packets with a terminator.
module match_extractor #(
  parameter int DWIDTH = 256,
  parameter int NBYTES = 32,
  parameter int PWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic              in_eop,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_match,
  output logic [PWIDTH-1:0] out_pos,
  output logic [2:0]        out_filter,
  output logic              out_eop
);

  localparam int IW = $clog2(DWIDTH);

  typedef enum logic [1:0] {IDLE, SCAN, TERM} state_t;

  state_t            state, state_n;
  logic [DWIDTH-1:0] cand, cand_n, src;
  logic              eop_r, eop_n;
  logic [PWIDTH-1:0] base_r, base_n, word_base, word_base_n, base_sel;
  logic              valid_n, match_n, oeop_n;
  logic [PWIDTH-1:0] pos_n;
  logic [2:0]        filter_n;
  logic [IW-1:0]     idx;
  logic              found;

  assign in_ready = (state == IDLE);
  assign base_sel = in_sop ? '0 : word_base;

  // cand keeps the record currently presented as its lowest set bit, so the
  // post-handshake remainder is cand with its lowest bit cleared.
  assign src   = (state == IDLE) ? ~in_data : (cand & (cand - DWIDTH'(1)));
  assign found = |src;

  always_comb begin
    idx = '0;
    for (int i = DWIDTH - 1; i >= 0; i--) begin
      if (src[i]) idx = IW'(i);
    end
  end

  always_comb begin
    state_n     = state;
    cand_n      = cand;
    eop_n       = eop_r;
    base_n      = base_r;
    word_base_n = word_base;
    valid_n     = out_valid;
    match_n     = out_match;
    pos_n       = out_pos;
    filter_n    = out_filter;
    oeop_n      = out_eop;
    case (state)
      IDLE: begin
        if (in_valid) begin
          cand_n      = ~in_data;
          eop_n       = in_eop;
          base_n      = base_sel;
          word_base_n = base_sel + PWIDTH'(NBYTES);
          if (found) begin
            state_n  = SCAN;
            valid_n  = 1'b1;
            match_n  = 1'b1;
            pos_n    = base_sel + PWIDTH'(idx[IW-1:3]);
            filter_n = idx[2:0];
            oeop_n   = 1'b0;
          end else if (in_eop) begin
            state_n  = TERM;
            valid_n  = 1'b1;
            match_n  = 1'b0;
            pos_n    = '0;
            filter_n = '0;
            oeop_n   = 1'b1;
          end
        end
      end
      SCAN: begin
        if (out_ready) begin
          cand_n = src;
          if (found) begin
            pos_n    = base_r + PWIDTH'(idx[IW-1:3]);
            filter_n = idx[2:0];
          end else if (eop_r) begin
            state_n  = TERM;
            match_n  = 1'b0;
            pos_n    = '0;
            filter_n = '0;
            oeop_n   = 1'b1;
          end else begin
            state_n  = IDLE;
            valid_n  = 1'b0;
            match_n  = 1'b0;
            pos_n    = '0;
            filter_n = '0;
          end
        end
      end
      TERM: begin
        if (out_ready) begin
          state_n = IDLE;
          valid_n = 1'b0;
          oeop_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cand       <= '0;
      eop_r      <= 1'b0;
      base_r     <= '0;
      word_base  <= '0;
      out_valid  <= 1'b0;
      out_match  <= 1'b0;
      out_pos    <= '0;
      out_filter <= '0;
      out_eop    <= 1'b0;
    end else begin
      state      <= state_n;
      cand       <= cand_n;
      eop_r      <= eop_n;
      base_r     <= base_n;
      word_base  <= word_base_n;
      out_valid  <= valid_n;
      out_match  <= match_n;
      out_pos    <= pos_n;
      out_filter <= filter_n;
      out_eop    <= oeop_n;
    end
  end

endmodule

// File: tb/tb_match_extractor.sv
// tb/tb_match_extractor.sv - self-checking bench for match_extractor
module tb_match_extractor;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] in_data = '1;
  logic         in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic         out_ready = 1'b1;
  logic         in_ready, out_valid, out_match, out_eop;
  logic [15:0]  out_pos;
  logic [2:0]   out_filter;

  match_extractor dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
    .in_eop(in_eop), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_match(out_match), .out_pos(out_pos), .out_filter(out_filter), .out_eop(out_eop)
  );

  always #5 clk = ~clk;

  typedef struct { logic m; logic [15:0] p; logic [2:0] f; logic e; } rec_t;
  typedef struct {
    logic [255:0] d; logic s; logic e;
    logic v; logic m; logic [15:0] p; logic [2:0] f; logic eo;
  } vec_t;

  rec_t        exp_q[$];
  logic [15:0] mdl_wb = '0;
  int          checks = 0, failures = 0, hs_count = 0;
  logic        stall_p = 1'b0;
  logic [20:0] stall_f;
  logic        rand_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: every 0 bit of the beat becomes (byte offset, filter), in bit order.
  task automatic model_accept(input logic [255:0] d, input logic s, input logic e);
    rec_t r;
    int   base;
    base   = s ? 0 : int'(mdl_wb);
    mdl_wb = 16'((base + 32) % 65536);
    for (int i = 0; i < 256; i++) begin
      if (d[i] == 1'b0) begin
        r.m = 1'b1; r.p = 16'((base + i / 8) % 65536); r.f = 3'(i % 8); r.e = 1'b0;
        exp_q.push_back(r);
      end
    end
    if (e) begin
      r.m = 1'b0; r.p = '0; r.f = '0; r.e = 1'b1;
      exp_q.push_back(r);
    end
  endtask

  always @(negedge clk) begin
    rec_t r;
    if (rst) begin
      exp_q.delete();
      mdl_wb  = '0;
      stall_p = 1'b0;
    end else begin
      if (stall_p) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_fields", 32'({out_match, out_pos, out_filter, out_eop}), 32'(stall_f));
      end
      if (in_valid && in_ready) model_accept(in_data, in_sop, in_eop);
      if (out_valid && out_ready) begin
        hs_count++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_record actual=%0h required=none",
                   {out_match, out_pos, out_filter, out_eop});
        end else begin
          r = exp_q.pop_front();
          checks--;
          chk("record", 32'({out_match, out_pos, out_filter, out_eop}), 32'({r.m, r.p, r.f, r.e}));
        end
      end
      stall_p = out_valid && !out_ready;
      stall_f = {out_match, out_pos, out_filter, out_eop};
    end
  end

  task automatic send_beat(input logic [255:0] d, input logic s, input logic e);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 5000) begin @(negedge clk); n++; end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_data = d; in_sop = s; in_eop = e; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = $urandom();
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while (!(in_ready && !out_valid) && n < 5000) begin @(negedge clk); n++; end
    if (!(in_ready && !out_valid)) chk("drain_timeout", 32'({in_ready, out_valid}), 32'b10);
  endtask

  vec_t         tbl[6];
  logic [255:0] d;
  int           n0, n, bad, bi, bf;

  initial begin
    d = '1;
    tbl[0] = '{d, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0, 3'd0, 1'b1};
    d[0] = 1'b0; d[13] = 1'b0;
    tbl[1] = '{d, 1'b1, 1'b0, 1'b1, 1'b1, 16'd0, 3'd0, 1'b0};
    d = '1;
    tbl[2] = '{d, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 3'd0, 1'b1};
    tbl[3] = '{d, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 3'd0, 1'b0};
    d[255] = 1'b0;
    tbl[4] = '{d, 1'b0, 1'b1, 1'b1, 1'b1, 16'd63, 3'd7, 1'b0};
    d = '1; d[100] = 1'b0;
    tbl[5] = '{d, 1'b1, 1'b1, 1'b1, 1'b1, 16'd12, 3'd4, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'({out_valid, out_match, out_pos, out_filter, out_eop}), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 rst = 1'b0;

    for (int k = 0; k < 6; k++) begin
      send_beat(tbl[k].d, tbl[k].s, tbl[k].e);
      @(negedge clk);
      chk($sformatf("vec%0d_first", k), 32'({out_valid, out_match, out_pos, out_filter, out_eop}),
          32'({tbl[k].v, tbl[k].m, tbl[k].p, tbl[k].f, tbl[k].eo}));
      chk($sformatf("vec%0d_in_ready", k), 32'(in_ready), 32'(!tbl[k].v));
      drain();
    end

    out_ready = 1'b0;
    send_beat('0, 1'b1, 1'b1);
    @(negedge clk);
    chk("stall_first", 32'({out_valid, out_match, out_pos, out_filter, out_eop}), 32'(22'h200000 | 22'h100000));
    bad = 0;
    repeat (4) begin @(negedge clk); if (in_ready || !out_valid) bad++; end
    n0 = hs_count;
    @(posedge clk); #1 out_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (out_valid && n < 1000) begin
      if (in_ready) bad++;
      @(negedge clk); n++;
    end
    chk("stall_scan_in_ready_low", 32'(bad), 32'd0);
    chk("allzero_record_count", 32'(hs_count - n0), 32'd257);
    drain();

    send_beat('0, 1'b1, 1'b1);
    n0 = hs_count; n = 0;
    while (hs_count < n0 + 3 && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_scan", 32'({out_valid, in_ready}), 32'b01);
    bad = 0;
    repeat (10) begin @(negedge clk); if (out_valid) bad++; end
    chk("rst_no_records", 32'(bad), 32'd0);

    bi = $urandom_range(0, 31); bf = $urandom_range(0, 7);
    send_beat('1, 1'b1, 1'b0);
    for (int k = 1; k < 2048; k++) send_beat('1, 1'b0, 1'b0);
    d = '1; d[8 * bi + bf] = 1'b0;
    send_beat(d, 1'b0, 1'b1);
    @(negedge clk);
    chk("wrap_pos", 32'({out_valid, out_match, out_pos, out_filter}),
        32'({1'b1, 1'b1, 16'((2048 * 32 + bi) % 65536), 3'(bf)}));
    drain();

    fork
      begin
        for (int k = 0; k < 150; k++) begin
          d = '1;
          if ($urandom_range(0, 15) == 0) d = '0;
          else for (int j = $urandom_range(0, 4); j > 0; j--) d[$urandom_range(0, 255)] = 1'b0;
          send_beat(d, (k == 0) || ($urandom_range(0, 3) == 0), $urandom_range(0, 2) == 0);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1)); end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
